ram_responder: RTL and testbench
================================

Name: ram_responder

Overview:
- Synchronous, word-addressed RAM that sits on the RAM side of memory_control and serves its ramREN/ramWEN/ramaddr/ramstore requests.
- Returns ramload and the ramstate_t handshake (FREE/BUSY/ACCESS/ERROR) after a programmable latency.
- Restarts latency whenever the arbitrated request changes mid-flight, for example when an I-fetch is pre-empted by a D-access.
- Replaces the behavioural RAM model in system-level simulation and synthesizes for FPGA prototyping.

Parameters:
- LAT, 2, BUSY cycles between request acceptance and ACCESS; legal range 0..15.
- ADDR_BITS, 8, word-index width; depth = 2**ADDR_BITS words of 32 bits.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  asynchronous, active-low reset.
- ramREN  in  1  read request.
- ramWEN  in  1  write request.
- ramaddr  in  32  byte address (word_t).
- ramstore  in  32  write data (word_t).
- ramload  out  32  read data (word_t), registered.
- ramstate  out  2  ramstate_t from cpu_types_pkg, registered: FREE, BUSY, ACCESS, ERROR.

Behaviour:
- Reset (async, nRST=0):
  - ramstate=FREE, ramload=0, latency counter=0, latched request cleared.
  - All memory words=0.
  - Applies mid-transaction too; a pending write is discarded.
- Request classification (combinational, every cycle):
  - none: ramREN=0 and ramWEN=0.
  - illegal: ramREN=ramWEN=1; or ramaddr[1:0]!=0; or ramaddr[31:ADDR_BITS+2]!=0.
  - legal: read or write otherwise.
- Latched request: {REN, WEN, ramaddr}, captured when a transaction starts. The request "matches" when current {ramREN, ramWEN, ramaddr} equals the latch. ramstore is not part of the match.
- FSM, state = ramstate. Every transition is evaluated at the rising edge.
  - FREE:
    - none -> FREE.
    - illegal -> ERROR.
    - legal -> latch request; LAT>0 -> BUSY with count=LAT-1; LAT=0 -> ACCESS.
  - BUSY:
    - none -> FREE.
    - illegal -> ERROR.
    - legal and not match -> relatch; LAT>0 -> BUSY with count=LAT-1; LAT=0 -> ACCESS.
    - match and count=0 -> ACCESS.
    - match and count>0 -> count-1.
  - ACCESS: lasts exactly one cycle.
    - Write, if the request still matches at the edge ending ACCESS: mem[ramaddr[ADDR_BITS+1:2]] <= ramstore sampled at that edge.
    - If the request no longer matches at that edge, the write is dropped.
    - Next state: evaluated exactly as from FREE. A held request therefore starts a fresh transaction with the full latency; there is no back-to-back ACCESS for LAT>0.
  - ERROR: evaluated exactly as from FREE every cycle. Remains ERROR while the request is illegal.
- ramload:
  - On the edge entering ACCESS for a read: loaded with mem[latched index].
  - That value is held through ACCESS and until the next read entry.
  - Writes never change ramload.
  - Reads are not forwarded from a write committing on the same edge; the old word is returned.
- Latency: a read presented continuously from cycle 0 sees ramstate=ACCESS and valid ramload in cycle LAT+1.
- Memory is single-port; exactly one access per transaction.

Test Plan:
- Reset then idle, LAT=2 -> ramstate=FREE, ramload=0 every cycle. Assert nRST=0 during BUSY -> ramstate=FREE immediately (async), no write committed.
- Write 0xDEADBEEF to 0x0000_0010, held until ACCESS, LAT=2:
  - ramstate BUSY,BUSY,ACCESS in cycles 1-3.
  - Then read 0x10 -> ACCESS in cycle 3 of the read, ramload=0xDEADBEEF.
  - Read 0x14 -> ramload=0.
- Read 0x20 (I-fetch), switch to 0x40 in cycle 2 while BUSY:
  - count restarts; ACCESS appears 3 cycles after the switch.
  - ramload=mem[0x40 index], never mem[0x20 index].
- Illegal requests:
  - ramREN=ramWEN=1 -> ERROR next cycle.
  - Address 0x0000_0012 -> ERROR.
  - Address 0x0000_0400 with ADDR_BITS=8 -> ERROR; no memory word changes.
  - Drop the request -> FREE next cycle.
- Held read at 0x8 with LAT=1 -> ramstate pattern BUSY,ACCESS,BUSY,ACCESS... Repeat with LAT=0 -> ACCESS every cycle, ramload stable.
- Write to 0x8 aborted (ramWEN drops during BUSY, and separately drops during ACCESS) -> later read of 0x8 returns the prior value.

Source files
------------

// File: rtl/ram_responder.sv
// ram_responder: word-addressed 32-bit RAM serving memory_control requests
// with a FREE/BUSY/ACCESS/ERROR handshake after LAT busy cycles.
module ram_responder #(
   parameter int LAT       = 2,
   parameter int ADDR_BITS = 8
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ramREN,
   input  logic        ramWEN,
   input  logic [31:0] ramaddr,
   input  logic [31:0] ramstore,
   output logic [31:0] ramload,
   output logic [1:0]  ramstate
);
   typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} state_t;
   localparam logic [3:0] LAT_M1 = 4'(LAT > 0 ? LAT - 1 : 0);
   state_t state;
   logic [31:0] mem [2**ADDR_BITS];
   logic lat_ren, lat_wen;
   logic [31:0] lat_addr;
   logic [3:0] count;
   logic none, illegal, match, start;
   logic [ADDR_BITS-1:0] idx, lat_idx;
   always_comb begin
      none    = !ramREN && !ramWEN;
      illegal = (ramREN && ramWEN) || ramaddr[1:0] != 2'b0 || (ramaddr >> (ADDR_BITS + 2)) != 32'b0;
      match   = {ramREN, ramWEN, ramaddr} == {lat_ren, lat_wen, lat_addr};
      // BUSY keeps counting only while the same request is held; anything legal else restarts
      start   = !none && !illegal && (state != BUSY || !match);
      idx     = ramaddr[ADDR_BITS+1:2];
      lat_idx = lat_addr[ADDR_BITS+1:2];
   end
   assign ramstate = state;
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state    <= FREE;
         ramload  <= '0;
         count    <= '0;
         lat_ren  <= 1'b0;
         lat_wen  <= 1'b0;
         lat_addr <= '0;
         for (int i = 0; i < 2**ADDR_BITS; i++) mem[i] <= '0;
      end else begin
         if (state == ACCESS && lat_wen && match) mem[lat_idx] <= ramstore;
         if (start) begin
            lat_ren  <= ramREN;
            lat_wen  <= ramWEN;
            lat_addr <= ramaddr;
            count    <= LAT_M1;
            state    <= LAT > 0 ? BUSY : ACCESS;
            if (LAT == 0 && ramREN) ramload <= mem[idx];
         end else if (none) begin
            state <= FREE;
         end else if (illegal) begin
            state <= ERROR;
         end else if (count == 4'd0) begin
            state <= ACCESS;
            if (lat_ren) ramload <= mem[lat_idx];
         end else begin
            count <= count - 4'd1;
         end
      end
   end
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: scoreboard bench for ram_responder at LAT=2, 1 and 0.
module tb_ram_responder;
   localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
   logic CLK, nRST, ren, wen;
   logic [31:0] addr, store, ld2, ld1, ld0, ld_exp;
   logic [1:0] st2, st1, st0;
   int checks = 0, errors = 0;
   typedef struct {
      string tag;
      int dut;
      logic [1:0] st;
      logic [31:0] ld;
   } exp_t;
   exp_t sb[$];

   ram_responder #(.LAT(2), .ADDR_BITS(8)) d2 (.CLK(CLK), .nRST(nRST), .ramREN(ren), .ramWEN(wen),
      .ramaddr(addr), .ramstore(store), .ramload(ld2), .ramstate(st2));
   ram_responder #(.LAT(1), .ADDR_BITS(8)) d1 (.CLK(CLK), .nRST(nRST), .ramREN(ren), .ramWEN(wen),
      .ramaddr(addr), .ramstore(store), .ramload(ld1), .ramstate(st1));
   ram_responder #(.LAT(0), .ADDR_BITS(8)) d0 (.CLK(CLK), .nRST(nRST), .ramREN(ren), .ramWEN(wen),
      .ramaddr(addr), .ramstore(store), .ramload(ld0), .ramstate(st0));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] st_of(input int d);
      return {30'b0, d == 0 ? st0 : d == 1 ? st1 : st2};
   endfunction

   function automatic logic [31:0] ld_of(input int d);
      return d == 0 ? ld0 : d == 1 ? ld1 : ld2;
   endfunction

   task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] s);
      ren = r; wen = w; addr = a; store = s;
   endtask

   task automatic push(input string tag, input int d, input logic [1:0] st, input logic [31:0] ld);
      exp_t e;
      e.tag = tag; e.dut = d; e.st = st; e.ld = ld;
      sb.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge CLK);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check({e.tag, " state"}, st_of(e.dut), {30'b0, e.st});
         check({e.tag, " load"}, ld_of(e.dut), e.ld);
      end
   endtask

   task automatic cyc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] s,
                      input string tag, input logic [1:0] st);
      drive(r, w, a, s);
      push(tag, 2, st, ld_exp);
      tick();
   endtask

   // write held through the edge that ends ACCESS, which also restarts a fresh BUSY
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      cyc(0, 1, a, d, "wr", BUSY);
      cyc(0, 1, a, d, "wr", BUSY);
      cyc(0, 1, a, d, "wr", ACCESS);
      cyc(0, 1, a, d, "wr restart", BUSY);
      cyc(0, 0, 0, 0, "wr drop", FREE);
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] d, input string tag);
      cyc(1, 0, a, 0, tag, BUSY);
      cyc(1, 0, a, 0, tag, BUSY);
      ld_exp = d;
      cyc(1, 0, a, 0, tag, ACCESS);
   endtask

   initial begin
      nRST = 1'b1;
      ld_exp = '0;
      drive(0, 0, 0, 0);
      #1 nRST = 1'b0;
      #2;
      check("reset state", {30'b0, st2}, {30'b0, FREE});
      check("reset load", ld2, 32'h0);
      @(negedge CLK) nRST = 1'b1;
      repeat (3) cyc(0, 0, 0, 0, "idle", FREE);

      wr(32'h10, 32'hDEADBEEF);
      rd(32'h10, 32'hDEADBEEF, "rd 0x10");
      rd(32'h14, 32'h0, "rd 0x14");
      cyc(0, 0, 0, 0, "rd drop", FREE);

      wr(32'h20, 32'hAAAA5555);
      wr(32'h40, 32'h40404040);
      cyc(1, 0, 32'h20, 0, "ifetch", BUSY);
      cyc(1, 0, 32'h20, 0, "ifetch", BUSY);
      cyc(1, 0, 32'h40, 0, "switch", BUSY);
      cyc(1, 0, 32'h40, 0, "switch", BUSY);
      ld_exp = 32'h40404040;
      cyc(1, 0, 32'h40, 0, "switch", ACCESS);
      cyc(0, 0, 0, 0, "switch drop", FREE);

      cyc(1, 1, 32'h10, 0, "both", ERROR);
      cyc(1, 0, 32'h12, 0, "misalign", ERROR);
      cyc(0, 1, 32'h400, 32'hFFFFFFFF, "range", ERROR);
      cyc(0, 1, 32'h400, 32'hFFFFFFFF, "range", ERROR);
      cyc(0, 0, 0, 0, "err drop", FREE);
      rd(32'h0, 32'h0, "rd 0x0");
      cyc(0, 0, 0, 0, "rd drop", FREE);

      wr(32'h8, 32'h11111111);
      cyc(0, 1, 32'h8, 32'h22222222, "abort busy", BUSY);
      cyc(0, 0, 0, 0, "abort busy", FREE);
      cyc(0, 1, 32'h8, 32'h22222222, "abort access", BUSY);
      cyc(0, 1, 32'h8, 32'h22222222, "abort access", BUSY);
      cyc(0, 1, 32'h8, 32'h22222222, "abort access", ACCESS);
      cyc(0, 0, 0, 0, "abort access", FREE);
      rd(32'h8, 32'h11111111, "rd 0x8");
      cyc(0, 0, 0, 0, "rd drop", FREE);

      cyc(0, 1, 32'h8, 32'h33333333, "rst busy", BUSY);
      #2 nRST = 1'b0;
      drive(0, 0, 0, 0);
      #1;
      ld_exp = '0;
      check("async reset state", {30'b0, st2}, {30'b0, FREE});
      check("async reset load", ld2, 32'h0);
      @(negedge CLK) nRST = 1'b1;
      rd(32'h8, 32'h0, "rd after rst");
      cyc(0, 0, 0, 0, "rd drop", FREE);

      wr(32'h8, 32'h33333333);
      for (int k = 1; k <= 6; k++) begin
         drive(1, 0, 32'h8, 0);
         push("lat1 held", 1, k % 2 == 1 ? BUSY : ACCESS, k >= 2 ? 32'h33333333 : 32'h0);
         push("lat0 held", 0, ACCESS, 32'h33333333);
         tick();
      end
      drive(0, 0, 0, 0);
      push("lat1 drop", 1, FREE, 32'h33333333);
      push("lat0 drop", 0, FREE, 32'h33333333);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
